msg_framer_mc: RTL and testbench

//   Multi-channel message framing tracker. Next generation of the single-channel

---
 rtl/msg_framer_mc.sv | 187 ++++++++++++++++++
 tb/tb_msg_framer_mc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_framer_mc.sv
// msg_framer_mc: NUM_CH independent IDLE/HEAD/DATA/TAIL framers sharing one interleaved beat bus.
// Optional per-channel idle-timeout abort is compiled in with `define FRAMER_TIMEOUT_EN.
module msg_framer_mc #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned MAX_LEN = 255,
   parameter int unsigned TIMEOUT = 16,
   localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic              in_head,
   input  logic              in_tail,
   input  logic [CH_W-1:0]   in_ch,
   output logic [NUM_CH-1:0] msg_ip,
   output logic              done_valid,
   output logic [CH_W-1:0]   done_ch,
   output logic [LEN_W-1:0]  done_len,
   output logic              err_valid,
   output logic [CH_W-1:0]   err_ch,
   output logic [1:0]        err_code,
   output logic [NUM_CH-1:0] timeout_err
);

   typedef enum logic [1:0] {IDLE = 2'b00, HEAD = 2'b01, DATA = 2'b10, TAIL = 2'b11} state_e;

   localparam logic [1:0] ERR_ORPHAN   = 2'b01;
   localparam logic [1:0] ERR_HEAD_IN  = 2'b10;
   localparam logic [1:0] ERR_OVERFLOW = 2'b11;

   state_e            state_q [NUM_CH];
   state_e            state_d [NUM_CH];
   logic [LEN_W-1:0]  len_q   [NUM_CH];
   logic [LEN_W-1:0]  len_d   [NUM_CH];
   logic [NUM_CH-1:0] beat;
   logic [NUM_CH-1:0] active;

   logic              done_valid_q, done_valid_d;
   logic [CH_W-1:0]   done_ch_q,    done_ch_d;
   logic [LEN_W-1:0]  done_len_q,   done_len_d;
   logic              err_valid_q,  err_valid_d;
   logic [CH_W-1:0]   err_ch_q,     err_ch_d;
   logic [1:0]        err_code_q,   err_code_d;

`ifdef FRAMER_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_q [NUM_CH];
   logic [IDLE_W-1:0] idle_d [NUM_CH];
   logic [NUM_CH-1:0] timeout_q, timeout_d;
`endif

   always_comb begin
      beat   = '0;
      active = '0;
      msg_ip = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         beat[c]   = in_valid && (in_ch == CH_W'(c));
         active[c] = (state_q[c] == HEAD) || (state_q[c] == DATA);
         msg_ip[c] = (state_q[c] != IDLE);
      end
   end

   // A head beat restarts the channel identically from any state; only the
   // error report differs, so head handling is shared ahead of the state split.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      done_valid_d = 1'b0;
      done_ch_d    = done_ch_q;
      done_len_d   = done_len_q;
      err_valid_d  = 1'b0;
      err_ch_d     = err_ch_q;
      err_code_d   = err_code_q;
`ifdef FRAMER_TIMEOUT_EN
      timeout_d    = '0;
`endif
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (beat[c]) begin
            if (in_head) begin
               if (active[c]) begin
                  err_valid_d = 1'b1;
                  err_ch_d    = CH_W'(c);
                  err_code_d  = ERR_HEAD_IN;
               end
               len_d[c]   = LEN_W'(1);
               state_d[c] = in_tail ? TAIL : HEAD;
               if (in_tail) begin
                  done_valid_d = 1'b1;
                  done_ch_d    = CH_W'(c);
                  done_len_d   = LEN_W'(1);
               end
            end else if (!active[c]) begin
               state_d[c]  = IDLE;
               err_valid_d = 1'b1;
               err_ch_d    = CH_W'(c);
               err_code_d  = ERR_ORPHAN;
            end else if (len_q[c] == LEN_W'(MAX_LEN)) begin
               state_d[c]  = IDLE;
               len_d[c]    = '0;
               err_valid_d = 1'b1;
               err_ch_d    = CH_W'(c);
               err_code_d  = ERR_OVERFLOW;
            end else begin
               len_d[c]   = len_q[c] + LEN_W'(1);
               state_d[c] = in_tail ? TAIL : DATA;
               if (in_tail) begin
                  done_valid_d = 1'b1;
                  done_ch_d    = CH_W'(c);
                  done_len_d   = len_q[c] + LEN_W'(1);
               end
            end
         end else begin
            case (state_q[c])
               HEAD:    state_d[c] = DATA;
               TAIL:    state_d[c] = IDLE;
               default: state_d[c] = state_q[c];
            endcase
         end
`ifdef FRAMER_TIMEOUT_EN
         idle_d[c] = '0;
         if (active[c] && !beat[c]) begin
            if (idle_q[c] == IDLE_W'(TIMEOUT - 1)) begin
               state_d[c]   = IDLE;
               len_d[c]     = '0;
               timeout_d[c] = 1'b1;
            end else begin
               idle_d[c] = idle_q[c] + IDLE_W'(1);
            end
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_q[c] <= IDLE;
            len_q[c]   <= '0;
         end
         done_valid_q <= 1'b0;
         done_ch_q    <= '0;
         done_len_q   <= '0;
         err_valid_q  <= 1'b0;
         err_ch_q     <= '0;
         err_code_q   <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         done_valid_q <= done_valid_d;
         done_ch_q    <= done_ch_d;
         done_len_q   <= done_len_d;
         err_valid_q  <= err_valid_d;
         err_ch_q     <= err_ch_d;
         err_code_q   <= err_code_d;
      end
   end

`ifdef FRAMER_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            idle_q[c] <= '0;
         end
         timeout_q <= '0;
      end else begin
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_err = timeout_q;
`else
   // TIMEOUT only matters when the abort logic is built in.
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT != 0);
   assign timeout_err    = '0;
`endif

   assign done_valid = done_valid_q;
   assign done_ch    = done_ch_q;
   assign done_len   = done_len_q;
   assign err_valid  = err_valid_q;
   assign err_ch     = err_ch_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_msg_framer_mc.sv
// Self-checking bench for msg_framer_mc: directed scenarios plus random beats against a message-level model.
module tb_msg_framer_mc;
   localparam int NUM_CH  = 4;
   localparam int LEN_W   = 8;
   localparam int MAX_LEN = 4;
   localparam int TIMEOUT = 16;
   localparam int CH_W    = 2;
`ifdef FRAMER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0, in_head = 1'b0, in_tail = 1'b0;
   logic [CH_W-1:0]   in_ch = '0;
   logic [NUM_CH-1:0] msg_ip;
   logic              done_valid;
   logic [CH_W-1:0]   done_ch;
   logic [LEN_W-1:0]  done_len;
   logic              err_valid;
   logic [CH_W-1:0]   err_ch;
   logic [1:0]        err_code;
   logic [NUM_CH-1:0] timeout_err;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clock = ~clock;

   msg_framer_mc #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_head(in_head),
      .in_tail(in_tail), .in_ch(in_ch), .msg_ip(msg_ip), .done_valid(done_valid),
      .done_ch(done_ch), .done_len(done_len), .err_valid(err_valid), .err_ch(err_ch),
      .err_code(err_code), .timeout_err(timeout_err)
   );

   // Message-level model: a channel is either inside a message (open) or not;
   // "closing" marks the single cycle after a completed message.
   bit              m_open  [NUM_CH];
   bit              m_close [NUM_CH];
   int              m_cnt   [NUM_CH];
   int              m_idle  [NUM_CH];
   bit              m_done_v, m_err_v;
   int              m_done_ch, m_done_len, m_err_ch, m_err_code;
   logic [NUM_CH-1:0] m_to;

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_open[c] = 0; m_close[c] = 0; m_cnt[c] = 0; m_idle[c] = 0;
      end
      m_done_v = 0; m_err_v = 0; m_done_ch = 0; m_done_len = 0;
      m_err_ch = 0; m_err_code = 0; m_to = '0;
   endtask

   task automatic model_step(input bit v, input bit h, input bit t, input int ch);
      m_done_v = 0; m_err_v = 0; m_to = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_close[c] = 0;
         if (v && ch == c) begin
            m_idle[c] = 0;
            if (h) begin
               if (m_open[c]) begin m_err_v = 1; m_err_ch = c; m_err_code = 2; end
               if (t) begin
                  m_open[c] = 0; m_close[c] = 1;
                  m_done_v = 1; m_done_ch = c; m_done_len = 1;
               end else begin
                  m_open[c] = 1; m_cnt[c] = 1;
               end
            end else if (!m_open[c]) begin
               m_err_v = 1; m_err_ch = c; m_err_code = 1;
            end else if (m_cnt[c] + 1 > MAX_LEN) begin
               m_err_v = 1; m_err_ch = c; m_err_code = 3; m_open[c] = 0;
            end else if (t) begin
               m_open[c] = 0; m_close[c] = 1;
               m_done_v = 1; m_done_ch = c; m_done_len = m_cnt[c] + 1;
            end else begin
               m_cnt[c]++;
            end
         end else if (m_open[c] && TO_EN) begin
            m_idle[c]++;
            if (m_idle[c] == TIMEOUT) begin
               m_open[c] = 0; m_idle[c] = 0; m_to[c] = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [NUM_CH-1:0] model_ip();
      logic [NUM_CH-1:0] ip;
      for (int c = 0; c < NUM_CH; c++) ip[c] = m_open[c] | m_close[c];
      return ip;
   endfunction

   // Apply one cycle of input, advance the model, sample outputs 1 time unit after the edge.
   task automatic drive(input bit v, input bit h, input bit t, input int ch);
      in_valid = v; in_head = h; in_tail = t; in_ch = CH_W'(ch);
      if (reset_n) model_step(v, h, t, ch); else model_reset();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 0);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1, 1, 0, 2);
      n_cmp++; if (msg_ip !== 4'b0000) begin n_mis++; $display("FAIL reset_msg_ip: got %b want 0000", msg_ip); end
      n_cmp++; if ({done_valid, done_ch, done_len} !== 11'd0) begin n_mis++;
         $display("FAIL reset_done: got v=%b ch=%0d len=%0d want all 0", done_valid, done_ch, done_len); end
      n_cmp++; if ({err_valid, err_ch, err_code} !== 5'd0) begin n_mis++;
         $display("FAIL reset_err: got v=%b ch=%0d code=%b want all 0", err_valid, err_ch, err_code); end
      n_cmp++; if (timeout_err !== 4'b0000) begin n_mis++; $display("FAIL reset_timeout: got %b want 0000", timeout_err); end
      reset_n = 1'b1;
   endtask

   task automatic test_single_msg();
      apply_reset();
      drive(1, 1, 0, 0);
      n_cmp++; if (msg_ip !== 4'b0001) begin n_mis++; $display("FAIL single_ip_head: got %b want 0001", msg_ip); end
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 1, 0);
      n_cmp++; if ({done_valid, done_ch, done_len} !== {1'b1, 2'd0, 8'd4}) begin n_mis++;
         $display("FAIL single_done: got v=%b ch=%0d len=%0d want v=1 ch=0 len=4", done_valid, done_ch, done_len); end
      n_cmp++; if (msg_ip !== 4'b0001) begin n_mis++; $display("FAIL single_ip_tail: got %b want 0001", msg_ip); end
      idle(1);
      n_cmp++; if ({msg_ip, done_valid, done_len} !== {4'b0000, 1'b0, 8'd4}) begin n_mis++;
         $display("FAIL single_after: got ip=%b v=%b len=%0d want ip=0000 v=0 len=4 held", msg_ip, done_valid, done_len); end
   endtask

   task automatic test_head_tail();
      apply_reset();
      drive(1, 1, 1, 1);
      n_cmp++; if ({done_valid, done_ch, done_len, msg_ip} !== {1'b1, 2'd1, 8'd1, 4'b0010}) begin n_mis++;
         $display("FAIL ht_done: got v=%b ch=%0d len=%0d ip=%b want v=1 ch=1 len=1 ip=0010", done_valid, done_ch, done_len, msg_ip); end
      idle(1);
      n_cmp++; if (msg_ip !== 4'b0000) begin n_mis++; $display("FAIL ht_ip_after: got %b want 0000", msg_ip); end
   endtask

   task automatic test_interleave();
      int errs = 0;
      apply_reset();
      drive(1, 1, 0, 2); errs += err_valid;
      drive(1, 1, 0, 3); errs += err_valid;
      drive(1, 0, 0, 2); errs += err_valid;
      drive(1, 0, 1, 3); errs += err_valid;
      n_cmp++; if ({done_valid, done_ch, done_len} !== {1'b1, 2'd3, 8'd2}) begin n_mis++;
         $display("FAIL il_done3: got v=%b ch=%0d len=%0d want v=1 ch=3 len=2", done_valid, done_ch, done_len); end
      drive(1, 0, 1, 2); errs += err_valid;
      n_cmp++; if ({done_valid, done_ch, done_len} !== {1'b1, 2'd2, 8'd3}) begin n_mis++;
         $display("FAIL il_done2: got v=%b ch=%0d len=%0d want v=1 ch=2 len=3", done_valid, done_ch, done_len); end
      n_cmp++; if (errs !== 0) begin n_mis++; $display("FAIL il_no_err: got %0d err pulses want 0", errs); end
   endtask

   task automatic test_errors();
      apply_reset();
      drive(1, 0, 0, 0);
      n_cmp++; if ({err_valid, err_ch, err_code, msg_ip} !== {1'b1, 2'd0, 2'b01, 4'b0000}) begin n_mis++;
         $display("FAIL orphan: got v=%b ch=%0d code=%b ip=%b want v=1 ch=0 code=01 ip=0000", err_valid, err_ch, err_code, msg_ip); end
      drive(1, 1, 0, 0);
      drive(1, 1, 0, 0);
      n_cmp++; if ({err_valid, err_ch, err_code, done_valid, msg_ip} !== {1'b1, 2'd0, 2'b10, 1'b0, 4'b0001}) begin n_mis++;
         $display("FAIL head_in: got v=%b ch=%0d code=%b done=%b ip=%b want v=1 ch=0 code=10 done=0 ip=0001",
                  err_valid, err_ch, err_code, done_valid, msg_ip); end
      drive(1, 0, 1, 0);
      n_cmp++; if ({done_valid, done_len, err_valid, err_code} !== {1'b1, 8'd2, 1'b0, 2'b10}) begin n_mis++;
         $display("FAIL restart_len: got done=%b len=%0d err=%b code=%b want done=1 len=2 err=0 code=10 held",
                  done_valid, done_len, err_valid, err_code); end
      drive(1, 1, 0, 1);
      drive(1, 1, 1, 1);
      n_cmp++; if ({done_valid, done_ch, done_len, err_valid, err_ch, err_code} !== {1'b1, 2'd1, 8'd1, 1'b1, 2'd1, 2'b10}) begin n_mis++;
         $display("FAIL restart_ht: got done=%b ch=%0d len=%0d err=%b ch=%0d code=%b want done=1 ch=1 len=1 err=1 ch=1 code=10",
                  done_valid, done_ch, done_len, err_valid, err_ch, err_code); end
   endtask

   task automatic test_overflow();
      apply_reset();
      drive(1, 1, 0, 2);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 2);
      n_cmp++; if ({err_valid, msg_ip} !== {1'b0, 4'b0100}) begin n_mis++;
         $display("FAIL ovf_at_max: got err=%b ip=%b want err=0 ip=0100", err_valid, msg_ip); end
      drive(1, 0, 0, 2);
      n_cmp++; if ({err_valid, err_ch, err_code, done_valid, msg_ip} !== {1'b1, 2'd2, 2'b11, 1'b0, 4'b0000}) begin n_mis++;
         $display("FAIL ovf_data: got err=%b ch=%0d code=%b done=%b ip=%b want err=1 ch=2 code=11 done=0 ip=0000",
                  err_valid, err_ch, err_code, done_valid, msg_ip); end
      drive(1, 1, 0, 1);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 1);
      drive(1, 0, 1, 1);
      n_cmp++; if ({err_valid, err_ch, err_code, done_valid} !== {1'b1, 2'd1, 2'b11, 1'b0}) begin n_mis++;
         $display("FAIL ovf_tail: got err=%b ch=%0d code=%b done=%b want err=1 ch=1 code=11 done=0",
                  err_valid, err_ch, err_code, done_valid); end
      drive(1, 1, 0, 3);
      drive(1, 0, 0, 3);
      test_reset();
      drive(1, 0, 1, 3);
      n_cmp++; if ({done_valid, err_valid, err_code, msg_ip} !== {1'b0, 1'b1, 2'b01, 4'b0000}) begin n_mis++;
         $display("FAIL reset_discard: got done=%b err=%b code=%b ip=%b want done=0 err=1 code=01 ip=0000",
                  done_valid, err_valid, err_code, msg_ip); end
   endtask

   task automatic test_timeout();
      apply_reset();
      drive(1, 1, 0, 1);
      idle(15);
      n_cmp++; if ({timeout_err, msg_ip} !== {4'b0000, 4'b0010}) begin n_mis++;
         $display("FAIL to_before: got to=%b ip=%b want to=0000 ip=0010", timeout_err, msg_ip); end
      idle(1);
      n_cmp++; if ({timeout_err, msg_ip, done_valid} !== (TO_EN ? {4'b0010, 4'b0000, 1'b0} : {4'b0000, 4'b0010, 1'b0})) begin n_mis++;
         $display("FAIL to_expire: got to=%b ip=%b done=%b want to=%b ip=%b done=0", timeout_err, msg_ip, done_valid,
                  TO_EN ? 4'b0010 : 4'b0000, TO_EN ? 4'b0000 : 4'b0010); end
      idle(1);
      n_cmp++; if (timeout_err !== 4'b0000) begin n_mis++; $display("FAIL to_pulse: got %b want 0000", timeout_err); end
      apply_reset();
      drive(1, 1, 0, 1);
      idle(15);
      drive(1, 0, 0, 1);
      idle(1);
      n_cmp++; if ({timeout_err, msg_ip} !== {4'b0000, 4'b0010}) begin n_mis++;
         $display("FAIL to_beat_wins: got to=%b ip=%b want to=0000 ip=0010", timeout_err, msg_ip); end
      drive(1, 0, 1, 1);
      n_cmp++; if ({done_valid, done_len} !== {1'b1, 8'd3}) begin n_mis++;
         $display("FAIL to_close: got v=%b len=%0d want v=1 len=3", done_valid, done_len); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            idle(18);
         end else begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
         end
         n_cmp++; if (msg_ip !== model_ip()) begin n_mis++;
            $display("FAIL rnd_ip @%0t: got %b want %b", $time, msg_ip, model_ip()); end
         n_cmp++; if ({done_valid, done_ch, done_len} !== {m_done_v, CH_W'(m_done_ch), LEN_W'(m_done_len)}) begin n_mis++;
            $display("FAIL rnd_done @%0t: got v=%b ch=%0d len=%0d want v=%b ch=%0d len=%0d", $time,
                     done_valid, done_ch, done_len, m_done_v, m_done_ch, m_done_len); end
         n_cmp++; if ({err_valid, err_ch, err_code} !== {m_err_v, CH_W'(m_err_ch), 2'(m_err_code)}) begin n_mis++;
            $display("FAIL rnd_err @%0t: got v=%b ch=%0d code=%0d want v=%b ch=%0d code=%0d", $time,
                     err_valid, err_ch, err_code, m_err_v, m_err_ch, m_err_code); end
         n_cmp++; if (timeout_err !== m_to) begin n_mis++;
            $display("FAIL rnd_timeout @%0t: got %b want %b", $time, timeout_err, m_to); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_msg();
      test_head_tail();
      test_interleave();
      test_errors();
      test_overflow();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
